// File: rtl/pipe_ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, mul/div
// FSM state encoding and the ID/EX pipeline register layout.
package pipe_ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_LUI  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIVU = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic        aluimm;
    logic        shift;
    logic [4:0]  wn;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
  } idex_t;

  function automatic logic is_muldiv(input logic [3:0] aluc);
    return (aluc == ALU_MUL) || (aluc == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative 32-step unsigned multiply / restoring divide unit.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         latch operands a/b and op select, clear the step counter
//   step          perform one iteration (asserted while the owner is BUSY)
//   op_div        1: divu a/b, 0: mul a*b (low 32 bits)
//   a, b          operands
//   result        quotient or product, valid after the 32nd step
//   div_by_zero   latched divisor is zero
//   last          this step is the 32nd one
module ex_muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        op_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        last
);

  logic        is_div;
  logic [4:0]  cnt;
  logic [31:0] acc, mcand, mplier;
  logic [31:0] rem, quo, dvsr;

  // Restoring division: shift the next dividend bit into the remainder and
  // subtract when it fits. rem < dvsr keeps rem_sh below 2^33, so diff[32]
  // is a clean borrow flag.
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] rem_nxt;

  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvsr};
    q_bit   = ~diff[32];
    rem_nxt = q_bit ? diff[31:0] : rem_sh[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else if (start) begin
      is_div <= op_div;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      rem    <= '0;
      quo    <= a;
      dvsr   <= b;
    end else if (step) begin
      // Both datapaths advance; op select only picks the result.
      cnt    <= cnt + 5'd1;
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nxt;
      quo    <= {quo[30:0], q_bit};
    end
  end

  assign last        = step && (cnt == 5'd31);
  assign result      = is_div ? quo : acc;
  assign div_by_zero = (dvsr == 32'd0);

endmodule

// File: rtl/pipe_ex_stage_muldiv.sv
// Execute stage: ID/EX register, single-cycle ALU and a 34-cycle iterative
// mul/divu with an IDLE/BUSY/DONE FSM that stalls IF/ID while it runs.
// Ports:
//   clk, clrn                 clock, synchronous active-high reset
//   ID*                       decoded instruction from ID (controls, operands)
//   EXwreg/EXm2reg/EXwmem     controls to MEM (write enables forced 0 on stall)
//   EXwn, EXaluResult, EXqb   destination, result/address, store data to MEM
//   stall                     freeze PC and IF/ID this cycle
module pipe_ex_stage_muldiv
  import pipe_ex_pkg::*;
#(
  parameter logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        IDwreg,
  input  logic        IDm2reg,
  input  logic        IDwmem,
  input  logic [3:0]  IDaluc,
  input  logic        IDaluimm,
  input  logic        IDshift,
  input  logic [4:0]  IDwn,
  input  logic [31:0] IDqa,
  input  logic [31:0] IDqb,
  input  logic [31:0] IDimm,
  output logic        EXwreg,
  output logic        EXm2reg,
  output logic        EXwmem,
  output logic [4:0]  EXwn,
  output logic [31:0] EXaluResult,
  output logic [31:0] EXqb,
  output logic        stall
);

  idex_t       idex, idin;
  logic [1:0]  state;
  logic        md_start, md_step, md_last, md_div0;
  logic [31:0] md_result, md_res;
  logic [31:0] a, b, alu_res;

  assign idin = '{wreg: IDwreg, m2reg: IDm2reg, wmem: IDwmem, aluc: IDaluc,
                  aluimm: IDaluimm, shift: IDshift, wn: IDwn,
                  qa: IDqa, qb: IDqb, imm: IDimm};

  assign md_start = (state == ST_IDLE) && is_muldiv(idex.aluc);
  assign md_step  = (state == ST_BUSY);
  assign stall    = md_start || md_step;

  always_ff @(posedge clk) begin
    if (clrn) begin
      idex  <= '0;
      state <= ST_IDLE;
    end else begin
      if (!stall) idex <= idin;
      case (state)
        ST_IDLE: if (md_start) state <= ST_BUSY;
        ST_BUSY: if (md_last)  state <= ST_DONE;
        default: state <= ST_IDLE;   // DONE hands over to the next instruction
      endcase
    end
  end

  ex_muldiv_iter u_muldiv (
    .clk         (clk),
    .rst         (clrn),
    .start       (md_start),
    .step        (md_step),
    .op_div      (idex.aluc == ALU_DIVU),
    .a           (a),
    .b           (b),
    .result      (md_result),
    .div_by_zero (md_div0),
    .last        (md_last)
  );

  assign md_res = (idex.aluc == ALU_DIVU && md_div0) ? DIV0_RESULT : md_result;

  assign a = idex.shift  ? {27'b0, idex.imm[10:6]} : idex.qa;
  assign b = idex.aluimm ? idex.imm : idex.qb;

  // Mul/div codes show the iterator output; it is only meaningful in DONE,
  // and before that the write enables are masked by stall.
  always_comb begin
    alu_res = a + b;
    case (idex.aluc)
      ALU_SUB:  alu_res = a - b;
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_LUI:  alu_res = {b[15:0], 16'b0};
      ALU_SLL:  alu_res = b << a[4:0];
      ALU_SRL:  alu_res = b >> a[4:0];
      ALU_SRA:  alu_res = $signed(b) >>> a[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(a) < $signed(b)};
      ALU_MUL,
      ALU_DIVU: alu_res = md_res;
      default:  alu_res = a + b;
    endcase
  end

  assign EXwreg      = idex.wreg & ~stall;
  assign EXwmem      = idex.wmem & ~stall;
  assign EXm2reg     = idex.m2reg;
  assign EXwn        = idex.wn;
  assign EXqb        = idex.qb;
  assign EXaluResult = alu_res;

endmodule

// File: tb/tb_pipe_ex_stage_muldiv.sv
// Directed self-checking bench for the execute stage with mul/divu.
module tb_pipe_ex_stage_muldiv;
  import pipe_ex_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        IDwreg, IDm2reg, IDwmem, IDaluimm, IDshift;
  logic [3:0]  IDaluc;
  logic [4:0]  IDwn;
  logic [31:0] IDqa, IDqb, IDimm;
  logic        EXwreg, EXm2reg, EXwmem, stall;
  logic [4:0]  EXwn;
  logic [31:0] EXaluResult, EXqb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ex_stage_muldiv #(.DIV0_RESULT(32'hFFFF_FFFF)) dut (
    .clk(clk), .clrn(clrn),
    .IDwreg(IDwreg), .IDm2reg(IDm2reg), .IDwmem(IDwmem), .IDaluc(IDaluc),
    .IDaluimm(IDaluimm), .IDshift(IDshift), .IDwn(IDwn),
    .IDqa(IDqa), .IDqb(IDqb), .IDimm(IDimm),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem), .EXwn(EXwn),
    .EXaluResult(EXaluResult), .EXqb(EXqb), .stall(stall)
  );

  task automatic drive(input logic [3:0] aluc, input logic wreg, input logic m2reg,
                       input logic wmem, input logic [4:0] wn, input logic [31:0] qa,
                       input logic [31:0] qb, input logic [31:0] imm,
                       input logic sh, input logic ai);
    IDaluc = aluc; IDwreg = wreg; IDm2reg = m2reg; IDwmem = wmem; IDwn = wn;
    IDqa = qa; IDqb = qb; IDimm = imm; IDshift = sh; IDaluimm = ai;
  endtask

  task automatic nop();
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Called at a negedge inside a stall; returns at the first negedge with
  // stall low (or after a cycle budget). Counts write enables seen during stall.
  task automatic wait_stall(output int n, output int bad, output bit to);
    n = 0; bad = 0; to = 1'b0;
    while (stall === 1'b1 && !to) begin
      if (EXwreg !== 1'b0 || EXwmem !== 1'b0) bad++;
      n++;
      if (n > 100) to = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nop();
    clrn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (EXwreg !== 1'b0)       begin errors++; $display("FAIL reset EXwreg: got %b expected 0", EXwreg); end
    checks++; if (EXm2reg !== 1'b0)      begin errors++; $display("FAIL reset EXm2reg: got %b expected 0", EXm2reg); end
    checks++; if (EXwmem !== 1'b0)       begin errors++; $display("FAIL reset EXwmem: got %b expected 0", EXwmem); end
    checks++; if (EXwn !== 5'd0)         begin errors++; $display("FAIL reset EXwn: got %0d expected 0", EXwn); end
    checks++; if (EXaluResult !== 32'd0) begin errors++; $display("FAIL reset EXaluResult: got %h expected 0", EXaluResult); end
    checks++; if (EXqb !== 32'd0)        begin errors++; $display("FAIL reset EXqb: got %h expected 0", EXqb); end
    checks++; if (stall !== 1'b0)        begin errors++; $display("FAIL reset stall: got %b expected 0", stall); end
    clrn = 1'b0;
  endtask

  task automatic test_add();
    drive(ALU_ADD, 1'b1, 1'b0, 1'b0, 5'd8, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (EXaluResult !== 32'd8) begin errors++; $display("FAIL add result: got %h expected 8", EXaluResult); end
    checks++; if (EXwreg !== 1'b1)       begin errors++; $display("FAIL add EXwreg: got %b expected 1", EXwreg); end
    checks++; if (EXwn !== 5'd8)         begin errors++; $display("FAIL add EXwn: got %0d expected 8", EXwn); end
    checks++; if (EXqb !== 32'd3)        begin errors++; $display("FAIL add EXqb: got %h expected 3", EXqb); end
    checks++; if (stall !== 1'b0)        begin errors++; $display("FAIL add stall: got %b expected 0", stall); end
    // store: memory-write enable passes straight through when not stalled
    drive(ALU_ADD, 1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'hABCD, 32'h4, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (EXwmem !== 1'b1)          begin errors++; $display("FAIL store EXwmem: got %b expected 1", EXwmem); end
    checks++; if (EXaluResult !== 32'h104)  begin errors++; $display("FAIL store addr: got %h expected 104", EXaluResult); end
    nop();
  endtask

  typedef struct {
    logic [3:0]  aluc;
    logic [31:0] qa, qb, imm;
    logic        sh, ai;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v[13];
    v[0]  = '{ALU_SUB,  32'd5,         32'd8,         32'd0,         1'b0, 1'b0, 32'hFFFF_FFFD};
    v[1]  = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0,         1'b0, 1'b0, 32'h00F0_1234};
    v[2]  = '{ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'd0,         1'b0, 1'b0, 32'h0000_00FF};
    v[3]  = '{ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,         1'b0, 1'b0, 32'hF0F0_0F0F};
    v[4]  = '{ALU_LUI,  32'd0,         32'd0,         32'h0000_1234, 1'b0, 1'b1, 32'h1234_0000};
    v[5]  = '{ALU_SLL,  32'd0,         32'h0000_000F, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_00F0};
    v[6]  = '{ALU_SRL,  32'd0,         32'h8000_0000, 32'h0000_0100, 1'b1, 1'b0, 32'h0800_0000};
    v[7]  = '{ALU_SRA,  32'd0,         32'h8000_0000, 32'h0000_0100, 1'b1, 1'b0, 32'hF800_0000};
    v[8]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0, 32'd1};
    v[9]  = '{ALU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 32'd0};
    v[10] = '{ALU_ADD,  32'hFFFF_FFFF, 32'd2,         32'd0,         1'b0, 1'b0, 32'd1};
    v[11] = '{4'd13,    32'd10,        32'd20,        32'd0,         1'b0, 1'b0, 32'd30};
    v[12] = '{ALU_ADD,  32'd10,        32'd0,         32'hFFFF_FFFC, 1'b0, 1'b1, 32'd6};
    for (int i = 0; i < 13; i++) begin
      drive(v[i].aluc, 1'b1, 1'b0, 1'b0, 5'd1, v[i].qa, v[i].qb, v[i].imm, v[i].sh, v[i].ai);
      @(negedge clk);
      checks++;
      if (EXaluResult !== v[i].exp || stall !== 1'b0) begin
        errors++;
        $display("FAIL alu[%0d] aluc=%0d: got %h stall %b expected %h stall 0",
                 i, v[i].aluc, EXaluResult, stall, v[i].exp);
      end
    end
    nop();
  endtask

  task automatic test_mul();
    int n, bad; bit to;
    drive(ALU_MUL, 1'b1, 1'b0, 1'b0, 5'd3, 32'd7, 32'd6, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    // next instruction waits at the ID/EX input until DONE
    drive(ALU_ADD, 1'b1, 1'b0, 1'b0, 5'd9, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    wait_stall(n, bad, to);
    checks++; if (to)                     begin errors++; $display("FAIL mul timeout: stall still high after %0d cycles", n); end
    checks++; if (n != 33)                begin errors++; $display("FAIL mul stall cycles: got %0d expected 33", n); end
    checks++; if (bad != 0)               begin errors++; $display("FAIL mul bubble: %0d stall cycles with a write enable, expected 0", bad); end
    checks++; if (EXaluResult !== 32'd42) begin errors++; $display("FAIL mul result: got %h expected 2a", EXaluResult); end
    checks++; if (EXwreg !== 1'b1 || EXwn !== 5'd3) begin errors++; $display("FAIL mul done ctl: got wreg %b wn %0d expected 1 3", EXwreg, EXwn); end
    @(negedge clk);
    checks++; if (EXaluResult !== 32'd2 || EXwn !== 5'd9 || stall !== 1'b0)
      begin errors++; $display("FAIL mul follower: got %h wn %0d stall %b expected 2 wn 9 stall 0", EXaluResult, EXwn, stall); end
    nop();
    @(negedge clk);
  endtask

  task automatic test_divu();
    int n, bad; bit to;
    drive(ALU_DIVU, 1'b1, 1'b0, 1'b0, 5'd4, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    nop();
    wait_stall(n, bad, to);
    checks++; if (to || n != 33)          begin errors++; $display("FAIL divu stall cycles: got %0d expected 33", n); end
    checks++; if (EXaluResult !== 32'd14 || EXwreg !== 1'b1) begin errors++; $display("FAIL divu result: got %h wreg %b expected e wreg 1", EXaluResult, EXwreg); end
    @(negedge clk);
    // divide by zero; m2reg/wmem set to check the bubble masking on wmem
    drive(ALU_DIVU, 1'b1, 1'b1, 1'b1, 5'd6, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    nop();
    wait_stall(n, bad, to);
    checks++; if (to || n != 33)          begin errors++; $display("FAIL div0 stall cycles: got %0d expected 33", n); end
    checks++; if (bad != 0)               begin errors++; $display("FAIL div0 bubble: %0d stall cycles with a write enable, expected 0", bad); end
    checks++; if (EXaluResult !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0 result: got %h expected ffffffff", EXaluResult); end
    checks++; if (EXwmem !== 1'b1 || EXm2reg !== 1'b1 || EXwn !== 5'd6)
      begin errors++; $display("FAIL div0 done ctl: got wmem %b m2reg %b wn %0d expected 1 1 6", EXwmem, EXm2reg, EXwn); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, bad; bit to;
    drive(ALU_DIVU, 1'b1, 1'b0, 1'b0, 5'd4, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(ALU_DIVU, 1'b1, 1'b0, 1'b0, 5'd5, 32'd50, 32'd5, 32'd0, 1'b0, 1'b0);
    wait_stall(n, bad, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL b2b first stall cycles: got %0d expected 33", n); end
    checks++; if (EXaluResult !== 32'd14 || EXwn !== 5'd4 || EXwreg !== 1'b1)
      begin errors++; $display("FAIL b2b first: got %h wn %0d wreg %b expected e wn 4 wreg 1", EXaluResult, EXwn, EXwreg); end
    @(negedge clk);
    nop();
    wait_stall(n, bad, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL b2b second stall cycles: got %0d expected 33", n); end
    checks++; if (EXaluResult !== 32'd10 || EXwn !== 5'd5 || EXwreg !== 1'b1)
      begin errors++; $display("FAIL b2b second: got %h wn %0d wreg %b expected a wn 5 wreg 1", EXaluResult, EXwn, EXwreg); end
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int seen;
    drive(ALU_MUL, 1'b1, 1'b0, 1'b0, 5'd7, 32'd7, 32'd6, 32'd0, 1'b0, 1'b0);
    @(negedge clk);               // IDLE with MUL held
    repeat (11) @(negedge clk);   // BUSY cycle 10
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy stall before reset: got %b expected 1", stall); end
    clrn = 1'b1;
    nop();
    @(negedge clk);
    clrn = 1'b0;
    checks++; if (stall !== 1'b0 || EXwreg !== 1'b0 || EXwn !== 5'd0 || EXaluResult !== 32'd0)
      begin errors++; $display("FAIL busy reset: got stall %b wreg %b wn %0d res %h expected all 0", stall, EXwreg, EXwn, EXaluResult); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall !== 1'b0 || EXwreg !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL busy reset residue: %0d cycles with stall or wreg, expected 0", seen); end
    drive(ALU_ADD, 1'b1, 1'b0, 1'b0, 5'd2, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (EXaluResult !== 32'd2 || EXwreg !== 1'b1) begin errors++; $display("FAIL post reset add: got %h wreg %b expected 2 wreg 1", EXaluResult, EXwreg); end
    nop();
    @(negedge clk);
  endtask

  initial begin
    clrn = 1'b1;
    nop();
    @(negedge clk);
    test_reset();
    test_add();
    test_alu();
    test_mul();
    test_divu();
    test_back_to_back();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
